// File: rtl/fcvt64_int.sv
// fcvt64_int: 3-stage valid/ready pipeline converting the fadd64 FP word
// (sign, 10-bit exponent biased by 511, 53-bit fraction, hidden 1) to int64/uint64.
module fcvt64_int #(
   parameter int         BIAS        = 511,
   parameter logic [9:0] EXP_SPECIAL = 10'h3FF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] A,
   input  logic        is_signed,
   input  logic        rm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] res,
   output logic        inexact,
   output logic        invalid
);
   localparam logic [1:0]  CLS_NORM = 2'd0;
   localparam logic [1:0]  CLS_ZERO = 2'd1;
   localparam logic [1:0]  CLS_SPEC = 2'd2;
   localparam logic [1:0]  CLS_OVF  = 2'd3;
   // Exponent codes for e = 64, e = 53 and e = -1 respectively.
   localparam logic [9:0]  EXP_OVF  = 10'(BIAS + 64);
   localparam logic [9:0]  EXP_LEFT = 10'(BIAS + 53);
   localparam logic [9:0]  EXP_TINY = 10'(BIAS - 1);
   localparam logic [63:0] INT_MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] INT_MIN  = 64'h8000_0000_0000_0000;

   typedef struct packed {
      logic        sign;
      logic        tsigned;
      logic        rm;
      logic [1:0]  cls;
      logic [9:0]  exp;
      logic [53:0] sig;
   } s1_t;

   typedef struct packed {
      logic        sign;
      logic        tsigned;
      logic        rm;
      logic [1:0]  cls;
      logic [63:0] mag;
      logic        rnd;
      logic        sticky;
   } s2_t;

   logic         en1, en2, en3;
   logic         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   s1_t          s1_q, s1_d;
   s2_t          s2_q, s2_d;
   logic [63:0]  res_q, res_d;
   logic         inexact_q, inexact_d;
   logic         invalid_q, invalid_d;
   logic [9:0]   shl_amt, shr_amt;
   logic [117:0] shr_full;
   logic [64:0]  sum;
   logic [63:0]  rmag, sat, val;
   logic         inc, bad;

   // A stage advances when it is empty or the stage after it advances.
   always_comb begin
      en3  = !v3_q || out_ready;
      en2  = !v2_q || en3;
      en1  = !v1_q || en2;
      v1_d = en1 ? in_valid : v1_q;
      v2_d = en2 ? v1_q : v2_q;
      v3_d = en3 ? v2_q : v3_q;
   end

   assign in_ready  = en1;
   assign out_valid = v3_q;
   assign res       = res_q;
   assign inexact   = inexact_q;
   assign invalid   = invalid_q;

   // S1: classify the operand.
   always_comb begin
      // NOTE: every always_comb output is given a default first so no path can infer a latch.
      s1_d = s1_q;
      if (en1 && in_valid) begin
         s1_d.sign    = A[63];
         s1_d.tsigned = is_signed;
         s1_d.rm      = rm;
         s1_d.exp     = A[62:53];
         s1_d.sig     = {1'b1, A[52:0]};
         if (A[62:53] == 10'd0)             s1_d.cls = CLS_ZERO;
         else if (A[62:53] == EXP_SPECIAL)  s1_d.cls = CLS_SPEC;
         else if (A[62:53] >= EXP_OVF)      s1_d.cls = CLS_OVF;
         else                               s1_d.cls = CLS_NORM;
      end
   end

   // S2: align the significand; bits shifted out form the round and sticky bits.
   always_comb begin
      s2_d     = s2_q;
      shl_amt  = s1_q.exp - EXP_LEFT;
      shr_amt  = EXP_LEFT - s1_q.exp;
      shr_full = {s1_q.sig, 64'd0} >> shr_amt;
      if (en2 && v1_q) begin
         s2_d.sign    = s1_q.sign;
         s2_d.tsigned = s1_q.tsigned;
         s2_d.rm      = s1_q.rm;
         s2_d.cls     = s1_q.cls;
         if (s1_q.exp >= EXP_LEFT) begin
            s2_d.mag    = {10'd0, s1_q.sig} << shl_amt;
            s2_d.rnd    = 1'b0;
            s2_d.sticky = 1'b0;
         end else if (s1_q.exp >= EXP_TINY) begin
            s2_d.mag    = {10'd0, shr_full[117:64]};
            s2_d.rnd    = shr_full[63];
            s2_d.sticky = |shr_full[62:0];
         end else begin
            s2_d.mag    = 64'd0;
            s2_d.rnd    = 1'b0;
            s2_d.sticky = 1'b1;
         end
      end
   end

   // S3: round, negate and saturate.
   always_comb begin
      res_d     = res_q;
      inexact_d = inexact_q;
      invalid_d = invalid_q;
      inc  = s2_q.rm && s2_q.rnd && (s2_q.sticky || s2_q.mag[0]);
      sum  = {1'b0, s2_q.mag} + {64'd0, inc};
      rmag = sum[63:0];
      if (s2_q.tsigned) sat = s2_q.sign ? INT_MIN : INT_MAX;
      else              sat = s2_q.sign ? 64'd0 : {64{1'b1}};
      bad = 1'b0;
      val = 64'd0;
      case (s2_q.cls)
         CLS_ZERO: bad = 1'b0;
         CLS_SPEC,
         CLS_OVF:  bad = 1'b1;
         default: begin
            if (sum[64])           bad = 1'b1;
            else if (s2_q.tsigned) bad = s2_q.sign ? (rmag > INT_MIN) : rmag[63];
            else                   bad = s2_q.sign && (rmag != 64'd0);
            val = s2_q.sign ? -rmag : rmag;
         end
      endcase
      if (en3 && v2_q) begin
         res_d     = bad ? sat : val;
         invalid_d = bad;
         inexact_d = !bad && (s2_q.cls == CLS_NORM) && (s2_q.rnd || s2_q.sticky);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         v3_q      <= 1'b0;
         s1_q      <= '0;
         s2_q      <= '0;
         res_q     <= 64'd0;
         inexact_q <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         // NOTE: state updates are non-blocking so every stage samples pre-edge values.
         v1_q      <= v1_d;
         v2_q      <= v2_d;
         v3_q      <= v3_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         res_q     <= res_d;
         inexact_q <= inexact_d;
         invalid_q <= invalid_d;
      end
   end
endmodule

// File: tb/tb_fcvt64_int.sv
// tb_fcvt64_int: directed vector table for the FP-to-integer converter, plus a
// stalled stream and an asynchronous reset with conversions in flight.
module tb_fcvt64_int;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic        is_signed;
   logic        rm;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] res;
   logic        inexact;
   logic        invalid;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [63:0] a;
      logic        sgn;
      logic        rm;
      logic [63:0] res;
      logic        inx;
      logic        inv;
      string       name;
   } vec_t;

   vec_t vecs[$];

   fcvt64_int dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a),
      .is_signed (is_signed),
      .rm        (rm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .inexact   (inexact),
      .invalid   (invalid)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [63:0] av, input logic sg, input logic r,
                               input logic [63:0] rv, input logic ix, input logic iv,
                               input string nm);
      vec_t v;
      v.a = av; v.sgn = sg; v.rm = r; v.res = rv; v.inx = ix; v.inv = iv; v.name = nm;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      a         = v.a;
      is_signed = v.sgn;
      rm        = v.rm;
   endtask

   // One isolated conversion with out_ready held high; also measures latency.
   task automatic run_vec(input vec_t v);
      int cyc;
      @(negedge clk);
      drive(v);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 10) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      check({v.name, "_latency"}, 64'(cyc), 64'd3);
      check({v.name, "_res"}, res, v.res);
      check({v.name, "_inexact"}, 64'(inexact), 64'(v.inx));
      check({v.name, "_invalid"}, 64'(invalid), 64'(v.inv));
   endtask

   // Eight operands back to back under a random out_ready pattern.
   task automatic stream_test();
      int          n_in  = 0;
      int          n_out = 0;
      int          cyc   = 0;
      logic        stalled = 1'b0;
      logic [63:0] held_res = 64'd0;
      logic [1:0]  held_flags = 2'b00;
      logic        fire_in;
      while (n_out < 8 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (n_in < 8);
         if (n_in < 8) drive(vecs[n_in]);
         #1;
         if (stalled) begin
            check("stream_stall_valid", 64'(out_valid), 64'd1);
            check("stream_stall_res", res, held_res);
            check("stream_stall_flags", 64'({inexact, invalid}), 64'(held_flags));
         end
         check("stream_in_ready", 64'(in_ready), 64'(((n_in - n_out) < 3) || out_ready));
         fire_in = in_valid && in_ready;
         if (out_valid && out_ready) begin
            check("stream_res", res, vecs[n_out].res);
            check("stream_flags", 64'({inexact, invalid}), 64'({vecs[n_out].inx, vecs[n_out].inv}));
            n_out++;
         end
         stalled    = out_valid && !out_ready;
         held_res   = res;
         held_flags = {inexact, invalid};
         if (fire_in) n_in++;
      end
      check("stream_count", 64'(n_out), 64'd8);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("stream_no_duplicate", 64'(out_valid), 64'd0);
      end
   endtask

   // Fill all three stages, then reset asynchronously between clock edges.
   task automatic reset_test();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(vecs[k]);
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("full_out_valid", 64'(out_valid), 64'd1);
      check("full_res", res, vecs[0].res);
      check("full_in_ready", 64'(in_ready), 64'd0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'd0);
      check("async_rst_res", res, 64'd0);
      check("async_rst_flags", 64'({inexact, invalid}), 64'd0);
      check("async_rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      run_vec(vecs[2]);
      @(negedge clk);
      check("post_rst_empty", 64'(out_valid), 64'd0);
   endtask

   initial begin
      vecs.push_back(mk(64'h3FE0_0000_0000_0000, 1, 0, 64'd1, 0, 0, "one_s"));
      vecs.push_back(mk(64'h4008_0000_0000_0000, 1, 1, 64'd2, 1, 0, "2p5_rne"));
      vecs.push_back(mk(64'h4018_0000_0000_0000, 1, 1, 64'd4, 1, 0, "3p5_rne"));
      vecs.push_back(mk(64'h4018_0000_0000_0000, 1, 0, 64'd3, 1, 0, "3p5_trunc"));
      vecs.push_back(mk(64'hBFE0_0000_0000_0000, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "m1_s"));
      vecs.push_back(mk(64'hBFE0_0000_0000_0000, 0, 0, 64'd0, 0, 1, "m1_u"));
      vecs.push_back(mk(64'hC7C0_0000_0000_0000, 1, 0, 64'h8000_0000_0000_0000, 0, 0, "m2p63_s"));
      vecs.push_back(mk(64'h47E0_0000_0000_0000, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, "2p64_s"));
      vecs.push_back(mk(64'h47E0_0000_0000_0000, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, "2p64_u"));
      vecs.push_back(mk(64'h0000_0000_0000_0000, 1, 1, 64'd0, 0, 0, "zero"));
      vecs.push_back(mk(64'h8000_0000_0000_0001, 0, 1, 64'd0, 0, 0, "negzero_u"));
      vecs.push_back(mk(64'h7FE0_0000_0000_0000, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, "inf_s"));
      vecs.push_back(mk(64'hFFE0_0000_0000_0000, 1, 0, 64'h8000_0000_0000_0000, 0, 1, "ninf_s"));
      vecs.push_back(mk(64'h7FE0_0000_0000_0123, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, "nan_u"));
      vecs.push_back(mk(64'h47C0_0000_0000_0000, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, "2p63_s"));
      vecs.push_back(mk(64'h47C0_0000_0000_0000, 0, 0, 64'h8000_0000_0000_0000, 0, 0, "2p63_u"));
      vecs.push_back(mk(64'h3FC0_0000_0000_0000, 1, 1, 64'd0, 1, 0, "0p5_rne"));
      vecs.push_back(mk(64'h3FF0_0000_0000_0000, 1, 1, 64'd2, 1, 0, "1p5_rne"));
      vecs.push_back(mk(64'hBFC0_0000_0000_0000, 0, 1, 64'd0, 1, 0, "m0p5_u_rne"));
      vecs.push_back(mk(64'hBFF0_0000_0000_0000, 0, 0, 64'd0, 0, 1, "m1p5_u"));
      vecs.push_back(mk(64'h3FA0_0000_0000_0000, 1, 1, 64'd0, 1, 0, "0p25_rne"));
      vecs.push_back(mk(64'hBFF0_0000_0000_0000, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, "m1p5_s_rne"));
      vecs.push_back(mk(64'h47A0_0000_0000_0001, 1, 0, 64'h4000_0000_0000_0200, 0, 0, "big_exact"));
      vecs.push_back(mk(64'hC7C0_0000_0000_0001, 1, 0, 64'h8000_0000_0000_0000, 0, 1, "below_min_s"));
      vecs.push_back(mk(64'h4008_0000_0000_0001, 1, 1, 64'd3, 1, 0, "2p5_sticky_rne"));
      vecs.push_back(mk(64'h467F_FFFF_FFFF_FFFF, 0, 1, 64'h0020_0000_0000_0000, 1, 0, "carry_rne"));

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 64'd0;
      is_signed = 1'b0;
      rm        = 1'b0;
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_res", res, 64'd0);
      check("reset_flags", 64'({inexact, invalid}), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
      stream_test();
      reset_test();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fcvt64_int.md
Name: fcvt64_int

Overview:
- Converts the 64-bit floating-point word produced by fadd64 back into a 64-bit integer (signed or unsigned), with selectable rounding.
- Operand format: sign bit 63, 10-bit biased exponent [62:53], 53-bit fraction [52:0], hidden leading 1.
- 3-stage valid/ready pipeline sitting between the FP result bus and the integer writeback path; full throughput of one conversion per clock when unstalled.

Parameters:
- BIAS, 511, exponent bias; unbiased exponent e = A[62:53] - BIAS.
- EXP_SPECIAL, 10'h3FF, exponent code treated as inf/NaN (always invalid).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  stage 1 can accept the operand this cycle.
- A  in  64  FP operand.
- is_signed  in  1  1 = signed int64 target, 0 = unsigned uint64.
- rm  in  1  0 = truncate toward zero, 1 = round to nearest, ties to even.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- res  out  64  integer result.
- inexact  out  1  result differs from the exact value (not set when invalid).
- invalid  out  1  overflow, inf/NaN code, or negative-to-unsigned with nonzero rounded magnitude.

Behaviour:
- Reset: v1, v2, v3 = 0; res = 0; inexact = 0; invalid = 0. Reset mid-operation discards all in-flight conversions; the first result after reset comes from the first post-reset handshake.
- Stage enables:
  - en3 = !v3 | out_ready; en2 = !v2 | en3; en1 = !v1 | en2; in_ready = en1 (combinational chain).
  - Stage k loads when en_k. The valid bit of stage k takes the valid bit of the stage before it.
  - Latency: 3 clocks from input handshake to out_valid when out_ready is held 1.
  - out_valid, res and the flags stay stable while out_valid & !out_ready.
  - The pipeline drops or duplicates no entry under any out_ready pattern.
- S1 classify (registered per entry):
  - E = A[62:53]; the sign, is_signed and rm travel with the entry.
  - E==0: zero class. Result 0, exact, never invalid, including the negative-sign case.
  - E==EXP_SPECIAL: special class.
  - e >= 64: overflow class.
  - Otherwise normal; the significand sig = {1, A[52:0]} (54 bits) is passed on.
- S2 shift:
  - 53 <= e <= 63: mag = sig << (e-53). Exact; round bit = 0, sticky = 0.
  - -1 <= e <= 52: mag = sig >> (53-e). Round bit = the last bit shifted out; sticky = OR of the remaining shifted-out bits.
  - e < -1: mag = 0, round = 0, sticky = 1.
  - mag is 64 bits and must not wrap.
- S3 round, negate, saturate:
  - rm=1: increment when round & (sticky | mag[0]). rm=0: no increment.
  - inexact = round | sticky.
  - A carry out of bit 63 on increment counts as overflow.
  - Signed target: positive with mag > 2^63-1 is invalid, res = 64'h7FFF_FFFF_FFFF_FFFF. Negative with mag > 2^63 is invalid, res = 64'h8000_0000_0000_0000. Negative with mag == 2^63 is valid, res = 64'h8000_0000_0000_0000. All other results are two's complement, res = sign ? -mag : mag.
  - Unsigned target: overflow is invalid, res = all ones. Negative with rounded mag != 0 is invalid, res = 0. Negative with rounded mag == 0 gives res = 0, inexact per rule, not invalid.
  - Special class: invalid = 1, saturated by sign as above.
  - Flag priority: when invalid = 1, force inexact = 0.

Test Plan:
- A=64'h3FE0_0000_0000_0000 (1.0), signed, rm=0 -> res=1, inexact=0, invalid=0, out_valid exactly 3 clocks after the handshake.
- A=64'h4008_0000_0000_0000 (2.5), rm=1 -> res=2, inexact=1. Then A=64'h4018_0000_0000_0000 (3.5), rm=1 -> res=4, inexact=1. With rm=0 -> res=3.
- A=64'hBFE0_0000_0000_0000 (-1.0): signed -> res=64'hFFFF_FFFF_FFFF_FFFF. Unsigned -> res=0, invalid=1.
- A=64'hC7C0_0000_0000_0000 (-2^63), signed -> res=64'h8000_0000_0000_0000, invalid=0. A=64'h47E0_0000_0000_0000 (2^64), signed -> res=64'h7FFF_FFFF_FFFF_FFFF, invalid=1. Same operand unsigned -> all ones, invalid=1.
- Back-to-back stream of 8 operands with out_ready toggled randomly -> all 8 results in order, none lost or duplicated, res held stable while stalled, in_ready=0 when all 3 stages are full and out_ready=0.
- Assert rst for 1 cycle with 3 entries in flight -> out_valid=0, res=0, flags=0 immediately (asynchronous). Next operand converts correctly after the 3-cycle latency.
